// File: rtl/song_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// song_reader : walks a song's ROM entries and hands notes to the note player
// Revision    : 1.0
// ============================================================================
module song_reader #(
   parameter int SONG_W = 2,
   parameter int IDX_W  = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       play,
   input  logic [SONG_W-1:0]          song,
   input  logic                       note_done,
   output logic [SONG_W+IDX_W-1:0]    rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]    rom_data,
   output logic [NOTE_W-1:0]          note,
   output logic [DUR_W-1:0]           duration,
   output logic                       new_note,
   output logic                       song_done,
   output logic                       busy
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_FETCH   = 3'd1;
   localparam logic [2:0] c_RDATA   = 3'd2;
   localparam logic [2:0] c_WAIT    = 3'd3;
   localparam logic [2:0] c_DONE    = 3'd4;
   localparam logic [2:0] c_STOPPED = 3'd5;

   logic [2:0]        r_state;
   logic [SONG_W-1:0] r_song_q;
   logic [IDX_W-1:0]  r_idx;
   logic [NOTE_W-1:0] r_note;
   logic [DUR_W-1:0]  r_duration;
   logic              r_new_note;

   logic [NOTE_W-1:0] w_rom_note;
   logic [DUR_W-1:0]  w_rom_dur;

   assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign w_rom_dur  = rom_data[DUR_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_IDLE;
         r_song_q   <= '0;
         r_idx      <= '0;
         r_note     <= '0;
         r_duration <= '0;
         r_new_note <= 1'b0;
      end else begin
         r_new_note <= 1'b0;
         case (r_state)
            c_IDLE: begin
               // A song change takes priority and costs one idle cycle
               if (song != r_song_q) begin
                  r_song_q <= song;
                  r_idx    <= '0;
               end else if (play) begin
                  r_state <= c_FETCH;
               end
            end
            c_FETCH: begin
               r_state <= play ? c_RDATA : c_IDLE;
            end
            c_RDATA: begin
               if (!play) begin
                  r_state <= c_IDLE;
               end else if (w_rom_dur == '0) begin
                  r_state <= c_DONE;
               end else begin
                  r_note     <= w_rom_note;
                  r_duration <= w_rom_dur;
                  r_new_note <= 1'b1;
                  r_state    <= c_WAIT;
               end
            end
            c_WAIT: begin
               // note_done coincident with new_note belongs to the previous note
               if (!play) begin
                  r_state <= c_IDLE;
               end else if (note_done && !r_new_note) begin
                  if (&r_idx) begin
                     r_state <= c_DONE;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= c_FETCH;
                  end
               end
            end
            c_DONE: begin
               r_idx   <= '0;
               r_state <= c_STOPPED;
            end
            c_STOPPED: begin
               if (!play) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = {r_song_q, r_idx};
   assign note      = r_note;
   assign duration  = r_duration;
   assign new_note  = r_new_note;
   assign song_done = (r_state == c_DONE);
   assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
